ram_mem_pipe: RTL and testbench
===============================

# ram_mem_pipe

Parametrised successor of the flat single-cycle simulation RAM. It serves one instruction port and one data port through the same `ram_read_helper` / `ram_write_helper` DPI-C backing store. Each port has a valid/ready request and response handshake, configurable response latency and an address-range error response. It sits between the core's fetch/LSU interfaces and the difftest memory model, so the core can be exercised against non-zero memory latency and backpressure.

## Interface
- `BASE_ADDR`, 64'h0000_0000_8000_0000: byte address of word index 0.
- `MEM_BYTES`, 64'h0000_0000_0800_0000: size of the legal window; legal iff `BASE_ADDR <= addr < BASE_ADDR+MEM_BYTES`.
- `INST_LATENCY`, 1: cycles from inst accept edge to `inst_resp_valid`; legal range 1..15.
- `DATA_LATENCY`, 2: same for the data port; legal range 1..15.
- `INST_WIDTH`, 32: 32 or 64; at 32, `addr[2]` selects the word half.
- `clk  in  1`: single clock, all state on posedge.
- `rst  in  1`: asynchronous, active-high reset.
- `inst_req_valid  in  1` / `inst_req_ready  out  1` / `inst_req_addr  in  64`: fetch request.
- `inst_resp_valid  out  1` / `inst_resp_ready  in  1` / `inst_resp_data  out  INST_WIDTH` / `inst_resp_err  out  1`: fetch response.
- `data_req_valid  in  1` / `data_req_ready  out  1` / `data_req_wen  in  1` / `data_req_addr  in  64` / `data_req_wdata  in  64` / `data_req_wmask  in  64`: load/store request; the mask is a bit mask.
- `data_resp_valid  out  1` / `data_resp_ready  in  1` / `data_resp_rdata  out  64` / `data_resp_err  out  1`: response. Writes also respond, with rdata 0.

## Operation
- The two ports are independent instances of one FSM: IDLE -> WAIT -> RESP -> IDLE. Each port has at most one outstanding request.
- IDLE:
  - `req_ready=1`.
  - Accept on `req_valid & req_ready` at the posedge.
  - Capture the error flag and read data; load the countdown with LATENCY-1.
  - Go to RESP if LATENCY==1, else to WAIT.
- WAIT:
  - `req_ready=0`.
  - Decrement the countdown each cycle.
  - At 0, go to RESP.
- RESP:
  - `resp_valid=1`; data and err are held stable until `resp_ready`.
  - On `resp_valid & resp_ready`, go to IDLE. The request is not accepted in that same cycle; `req_ready` rises the next cycle.
- Word index = `(addr - BASE_ADDR) >> 3`, 64-bit unsigned with wrap ignored. The legal check uses the full 64-bit compare.
- Legal read:
  - Call `ram_read_helper(1, idx)` combinationally in the accept cycle; register the result at the accept edge.
  - Inst at INST_WIDTH=32: `addr[2] ? word[63:32] : word[31:0]`.
- Legal write: at the accept edge, call `ram_write_helper(idx, wdata, wmask, 1)`. No other cycle calls it with wen=1.
- Illegal address:
  - No DPI write.
  - The read helper is called with en=0.
  - Response carries `err=1` and data 0.
  - Latency is unchanged.
- Same-edge hazard: an inst read accepted on the same edge as a data write to the same word returns the pre-write value.
- Data-port ordering: requests are strictly serialized, so a read accepted after a write's response returns the written data.

## Timing
- Reset values:
  - `*_req_ready=1`
  - `*_resp_valid=0`
  - `*_resp_data/rdata=0`
  - `*_resp_err=0`
  - FSMs in IDLE, countdowns 0.
- Reset asserted mid-WAIT or mid-RESP:
  - The pending response is dropped.
  - A write already performed at its accept edge is not undone.
- Latency: `resp_valid` rises exactly LATENCY posedges after the accept edge when `resp_ready` is held high.
- Minimum issue interval with `resp_ready` tied 1: LATENCY+1 cycles per port.
- Backpressure: `resp_ready=0` holds RESP indefinitely, and `req_ready` stays 0 throughout.
- `req_*` inputs are ignored outside IDLE.

## Test plan
- Reset, then check: both `req_ready=1`, both `resp_valid=0`, err=0, data=0.
- Inst at INST_LATENCY=1, INST_WIDTH=32:
  - Preload word 0 = 64'hAAAA_BBBB_1111_2222.
  - Fetch 0x8000_0000, then 0x8000_0004.
  - Expect 32'h1111_2222 one cycle after accept, then 32'hAAAA_BBBB.
- Data at DATA_LATENCY=3:
  - Write addr 0x8000_0010, wdata 64'hDEAD_BEEF_0000_0000, wmask 64'hFFFF_FFFF_0000_0000; then read the same addr.
  - Expect the write response 3 cycles after accept with rdata 0.
  - Expect the read to return DEAD_BEEF in the upper half and the preload value in the lower half.
- Illegal address:
  - Data read 0x7FFF_FFF8, and a write to BASE_ADDR+MEM_BYTES.
  - Expect `err=1`, rdata 0, backing store unchanged, latency = DATA_LATENCY.
- Backpressure:
  - Hold `data_resp_ready=0` for 5 cycles in RESP.
  - Expect `resp_valid` and rdata stable and `req_ready=0`; on release, handshake occurs and `req_ready=1` the next cycle.
- Reset mid-WAIT:
  - Assert `rst` 1 cycle after a write is accepted.
  - Expect no response, `resp_valid=0` immediately, and a subsequent read returning the written data.

Source files
------------

// File: rtl/ram_mem_pipe.sv
// -----------------------------------------------------------------------------
// ram_mem_pipe
//
// Pipelined simulation RAM with one instruction (fetch) port and one data
// (load/store) port sharing a single 64-bit word backing store. Each port
// accepts one request at a time over a valid/ready handshake. It returns a
// response after a configurable latency and holds that response until the
// consumer takes it. Addresses outside [BASE_ADDR, BASE_ADDR+MEM_BYTES) get
// an error response with zero data and never touch the store.
//
// The backing store is an internal word array that stands in for the
// ram_read_helper / ram_write_helper functions:
//   - a read is a combinational lookup enabled only for legal addresses;
//   - a write is a masked update on the accept edge of a legal data write.
// Only the low STORE_AW bits of the word index select a storage word, so
// word indices alias modulo 2**STORE_AW.
//
// Ports
//   clk, rst                 clock; asynchronous active-high reset
//   inst_req_valid/ready     fetch request handshake
//   inst_req_addr    [63:0]  fetch byte address
//   inst_resp_valid/ready    fetch response handshake
//   inst_resp_data   [IW]    fetched instruction data (IW = INST_WIDTH)
//   inst_resp_err            fetch address was out of range
//   data_req_valid/ready     load/store request handshake
//   data_req_wen             1 = store, 0 = load
//   data_req_addr    [63:0]  load/store byte address
//   data_req_wdata   [63:0]  store data
//   data_req_wmask   [63:0]  store bit mask (1 = write this bit)
//   data_resp_valid/ready    load/store response handshake
//   data_resp_rdata  [63:0]  load data (0 for stores and errors)
//   data_resp_err            load/store address was out of range
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

// -----------------------------------------------------------------------------
// ram_mem_pipe_port
//
// One port's request/response sequencer: IDLE -> WAIT -> RESP -> IDLE.
// In IDLE it captures the response payload on the accept edge. It then
// counts out the latency and presents the payload until it is consumed.
//
// Ports
//   clk, rst        clock; asynchronous active-high reset
//   req_valid_i     request offered
//   req_ready_o     port is idle and will accept
//   acc_data_i/err  response payload computed in the accept cycle
//   resp_valid_o    response presented
//   resp_ready_i    consumer takes the response
//   resp_data_o/err held response payload
// -----------------------------------------------------------------------------
module ram_mem_pipe_port #(
   parameter int unsigned LATENCY = 1,
   parameter int unsigned DW      = 64
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          req_valid_i,
   output logic          req_ready_o,
   input  logic [DW-1:0] acc_data_i,
   input  logic          acc_err_i,
   output logic          resp_valid_o,
   input  logic          resp_ready_i,
   output logic [DW-1:0] resp_data_o,
   output logic          resp_err_o
);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_WAIT,
      ST_RESP
   } state_e;

   localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

   state_e        state_q, state_d;
   logic [3:0]    cnt_q,   cnt_d;
   logic [DW-1:0] data_q,  data_d;
   logic          err_q,   err_d;

   // NOTE: every signal written here gets a default first, so no path through
   // the case statement can leave one unassigned and infer a latch.
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      data_d       = data_q;
      err_d        = err_q;
      req_ready_o  = 1'b0;
      resp_valid_o = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            req_ready_o = 1'b1;
            if (req_valid_i) begin
               data_d  = acc_data_i;
               err_d   = acc_err_i;
               cnt_d   = CNT_INIT;
               state_d = (LATENCY == 1) ? ST_RESP : ST_WAIT;
            end
         end
         ST_WAIT: begin
            // Moving to RESP on the edge where the count reaches 0 keeps
            // resp_valid exactly LATENCY cycles behind the request cycle.
            cnt_d = cnt_q - 4'd1;
            if (cnt_q <= 4'd1) begin
               cnt_d   = 4'd0;
               state_d = ST_RESP;
            end
         end
         ST_RESP: begin
            resp_valid_o = 1'b1;
            if (resp_ready_i) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // NOTE: non-blocking assignments make every register sample pre-edge
   // values, so the ordering of sequential blocks cannot change behaviour.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         cnt_q   <= 4'd0;
         data_q  <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         data_q  <= data_d;
         err_q   <= err_d;
      end
   end

   assign resp_data_o = data_q;
   assign resp_err_o  = err_q;

endmodule

// -----------------------------------------------------------------------------
// ram_mem_pipe (top)
// -----------------------------------------------------------------------------
module ram_mem_pipe #(
   parameter logic [63:0] BASE_ADDR    = 64'h0000_0000_8000_0000,
   parameter logic [63:0] MEM_BYTES    = 64'h0000_0000_0800_0000,
   parameter int unsigned INST_LATENCY = 1,
   parameter int unsigned DATA_LATENCY = 2,
   parameter int unsigned INST_WIDTH   = 32,
   parameter int unsigned STORE_AW     = 10
) (
   input  logic                  clk,
   input  logic                  rst,

   input  logic                  inst_req_valid,
   output logic                  inst_req_ready,
   input  logic [63:0]           inst_req_addr,
   output logic                  inst_resp_valid,
   input  logic                  inst_resp_ready,
   output logic [INST_WIDTH-1:0] inst_resp_data,
   output logic                  inst_resp_err,

   input  logic                  data_req_valid,
   output logic                  data_req_ready,
   input  logic                  data_req_wen,
   input  logic [63:0]           data_req_addr,
   input  logic [63:0]           data_req_wdata,
   input  logic [63:0]           data_req_wmask,
   output logic                  data_resp_valid,
   input  logic                  data_resp_ready,
   output logic [63:0]           data_resp_rdata,
   output logic                  data_resp_err
);

   localparam int unsigned STORE_WORDS = 1 << STORE_AW;

   logic [63:0] mem_q [STORE_WORDS];

   // --- address decode -------------------------------------------------------
   // Range checks compare the offset against MEM_BYTES, which equals the
   // full-width BASE_ADDR <= addr < BASE_ADDR+MEM_BYTES test without having
   // to form the (possibly overflowing) upper bound.
   logic [63:0]         inst_off, data_off;
   logic                inst_legal, data_legal;
   logic [STORE_AW-1:0] inst_idx, data_idx;

   assign inst_off   = inst_req_addr - BASE_ADDR;
   assign data_off   = data_req_addr - BASE_ADDR;
   assign inst_legal = (inst_req_addr >= BASE_ADDR) && (inst_off < MEM_BYTES);
   assign data_legal = (data_req_addr >= BASE_ADDR) && (data_off < MEM_BYTES);
   assign inst_idx   = inst_off[STORE_AW+2:3];
   assign data_idx   = data_off[STORE_AW+2:3];

   // --- read side (lookup enabled only for legal addresses) -----------------
   logic [63:0]           inst_word;
   logic [INST_WIDTH-1:0] inst_acc_data;
   logic [63:0]           data_acc_data;

   assign inst_word     = inst_legal ? mem_q[inst_idx] : 64'd0;
   // Stores answer with zero data; only legal loads see the store.
   assign data_acc_data = (data_legal && !data_req_wen) ? mem_q[data_idx] : 64'd0;

   if (INST_WIDTH == 64) begin : g_inst_w64
      assign inst_acc_data = inst_word;
   end else begin : g_inst_w32
      assign inst_acc_data = inst_req_addr[2] ? inst_word[63:32] : inst_word[31:0];
   end

   // --- write side -----------------------------------------------------------
   logic data_accept;
   assign data_accept = data_req_valid && data_req_ready;

   // NOTE: the store has no reset: it models memory contents, and a write
   // performed before a reset must survive it.
   always_ff @(posedge clk) begin
      if (!rst && data_accept && data_req_wen && data_legal) begin
         mem_q[data_idx] <= (mem_q[data_idx] & ~data_req_wmask) |
                            (data_req_wdata  &  data_req_wmask);
      end
   end

   // --- port sequencers ------------------------------------------------------
   ram_mem_pipe_port #(
      .LATENCY (INST_LATENCY),
      .DW      (INST_WIDTH)
   ) u_inst_port (
      .clk          (clk),
      .rst          (rst),
      .req_valid_i  (inst_req_valid),
      .req_ready_o  (inst_req_ready),
      .acc_data_i   (inst_acc_data),
      .acc_err_i    (!inst_legal),
      .resp_valid_o (inst_resp_valid),
      .resp_ready_i (inst_resp_ready),
      .resp_data_o  (inst_resp_data),
      .resp_err_o   (inst_resp_err)
   );

   ram_mem_pipe_port #(
      .LATENCY (DATA_LATENCY),
      .DW      (64)
   ) u_data_port (
      .clk          (clk),
      .rst          (rst),
      .req_valid_i  (data_req_valid),
      .req_ready_o  (data_req_ready),
      .acc_data_i   (data_acc_data),
      .acc_err_i    (!data_legal),
      .resp_valid_o (data_resp_valid),
      .resp_ready_i (data_resp_ready),
      .resp_data_o  (data_resp_rdata),
      .resp_err_o   (data_resp_err)
   );

endmodule

// File: tb/tb_ram_mem_pipe.sv
// -----------------------------------------------------------------------------
// tb_ram_mem_pipe
//
// Directed bench for ram_mem_pipe with INST_LATENCY=1, INST_WIDTH=32 and
// DATA_LATENCY=3. Drivers push the hand-computed response for every request
// they issue into a per-port queue. Per-port monitors compare each presented
// response against the queue head: arrival cycle, data and error flag.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_ram_mem_pipe;

   localparam int          ILAT = 1;
   localparam int          DLAT = 3;
   localparam logic [63:0] BASE = 64'h0000_0000_8000_0000;
   localparam logic [63:0] MEMB = 64'h0000_0000_0800_0000;

   logic        clk;
   logic        rst;
   logic        inst_req_valid, inst_req_ready;
   logic [63:0] inst_req_addr;
   logic        inst_resp_valid, inst_resp_ready;
   logic [31:0] inst_resp_data;
   logic        inst_resp_err;
   logic        data_req_valid, data_req_ready, data_req_wen;
   logic [63:0] data_req_addr, data_req_wdata, data_req_wmask;
   logic        data_resp_valid, data_resp_ready;
   logic [63:0] data_resp_rdata;
   logic        data_resp_err;

   ram_mem_pipe #(
      .BASE_ADDR    (BASE),
      .MEM_BYTES    (MEMB),
      .INST_LATENCY (ILAT),
      .DATA_LATENCY (DLAT),
      .INST_WIDTH   (32),
      .STORE_AW     (10)
   ) dut (
      .clk             (clk),
      .rst             (rst),
      .inst_req_valid  (inst_req_valid),
      .inst_req_ready  (inst_req_ready),
      .inst_req_addr   (inst_req_addr),
      .inst_resp_valid (inst_resp_valid),
      .inst_resp_ready (inst_resp_ready),
      .inst_resp_data  (inst_resp_data),
      .inst_resp_err   (inst_resp_err),
      .data_req_valid  (data_req_valid),
      .data_req_ready  (data_req_ready),
      .data_req_wen    (data_req_wen),
      .data_req_addr   (data_req_addr),
      .data_req_wdata  (data_req_wdata),
      .data_req_wmask  (data_req_wmask),
      .data_resp_valid (data_resp_valid),
      .data_resp_ready (data_resp_ready),
      .data_resp_rdata (data_resp_rdata),
      .data_resp_err   (data_resp_err)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Cycle number; a request offered in cycle R must be answered in R+LATENCY.
   int cyc = 0;
   initial forever begin
      @(posedge clk);
      cyc++;
   end

   typedef struct {
      logic [63:0] data;
      logic        err;
      int          due;
   } exp_t;

   exp_t inst_q[$];
   exp_t data_q[$];

   int chk_cnt  = 0;
   int pass_cnt = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      chk_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
   endtask

   // --- monitors ---------------------------------------------------------------
   bit inst_seen = 0;
   initial forever begin
      @(negedge clk);
      if (rst) begin
         inst_seen = 0;
      end else if (inst_resp_valid) begin
         if (inst_q.size() == 0) begin
            check("inst_spurious_resp", 64'(inst_resp_valid), 64'd0);
         end else begin
            if (!inst_seen) begin
               inst_seen = 1;
               check("inst_latency", 64'(cyc), 64'(inst_q[0].due));
            end
            check("inst_data", 64'(inst_resp_data), inst_q[0].data);
            check("inst_err", 64'(inst_resp_err), 64'(inst_q[0].err));
            if (inst_resp_ready) begin
               void'(inst_q.pop_front());
               inst_seen = 0;
            end
         end
      end
   end

   bit data_seen = 0;
   initial forever begin
      @(negedge clk);
      if (rst) begin
         data_seen = 0;
      end else if (data_resp_valid) begin
         if (data_q.size() == 0) begin
            check("data_spurious_resp", 64'(data_resp_valid), 64'd0);
         end else begin
            if (!data_seen) begin
               data_seen = 1;
               check("data_latency", 64'(cyc), 64'(data_q[0].due));
            end
            check("data_rdata", data_resp_rdata, data_q[0].data);
            check("data_err", 64'(data_resp_err), 64'(data_q[0].err));
            if (data_resp_ready) begin
               void'(data_q.pop_front());
               data_seen = 0;
            end
         end
      end
   end

   // --- drivers ----------------------------------------------------------------
   task automatic inst_req(input logic [63:0] addr, input logic [31:0] exp_data,
                           input logic exp_err);
      int n = 0;
      exp_t e;
      @(posedge clk); #1;
      inst_req_valid = 1'b1;
      inst_req_addr  = addr;
      while (!inst_req_ready) begin
         if (n == 50) begin
            check("inst_req_ready_timeout", 64'(inst_req_ready), 64'd1);
            break;
         end
         @(posedge clk); #1;
         n++;
      end
      e.data = 64'(exp_data);
      e.err  = exp_err;
      e.due  = cyc + ILAT;
      inst_q.push_back(e);
      @(posedge clk); #1;
      inst_req_valid = 1'b0;
   endtask

   task automatic data_req(input logic wen, input logic [63:0] addr,
                           input logic [63:0] wdata, input logic [63:0] wmask,
                           input logic [63:0] exp_data, input logic exp_err,
                           input bit track);
      int n = 0;
      exp_t e;
      @(posedge clk); #1;
      data_req_valid = 1'b1;
      data_req_wen   = wen;
      data_req_addr  = addr;
      data_req_wdata = wdata;
      data_req_wmask = wmask;
      while (!data_req_ready) begin
         if (n == 50) begin
            check("data_req_ready_timeout", 64'(data_req_ready), 64'd1);
            break;
         end
         @(posedge clk); #1;
         n++;
      end
      if (track) begin
         e.data = exp_data;
         e.err  = exp_err;
         e.due  = cyc + DLAT;
         data_q.push_back(e);
      end
      @(posedge clk); #1;
      data_req_valid = 1'b0;
      data_req_wen   = 1'b0;
   endtask

   task automatic wait_idle();
      int n = 0;
      forever begin
         @(negedge clk);
         if (inst_q.size() == 0 && data_q.size() == 0 && inst_req_ready && data_req_ready)
            break;
         n++;
         if (n == 200) begin
            check("idle_timeout", 64'(inst_q.size() + data_q.size()), 64'd0);
            break;
         end
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   // --- stimulus ---------------------------------------------------------------
   initial begin
      int n;
      rst             = 1'b1;
      inst_req_valid  = 1'b0;
      inst_req_addr   = '0;
      inst_resp_ready = 1'b1;
      data_req_valid  = 1'b0;
      data_req_wen    = 1'b0;
      data_req_addr   = '0;
      data_req_wdata  = '0;
      data_req_wmask  = '0;
      data_resp_ready = 1'b1;

      // Reset values, sampled while reset is held.
      repeat (3) @(negedge clk);
      check("rst_inst_req_ready",  64'(inst_req_ready),  64'd1);
      check("rst_data_req_ready",  64'(data_req_ready),  64'd1);
      check("rst_inst_resp_valid", 64'(inst_resp_valid), 64'd0);
      check("rst_data_resp_valid", 64'(data_resp_valid), 64'd0);
      check("rst_inst_resp_err",   64'(inst_resp_err),   64'd0);
      check("rst_data_resp_err",   64'(data_resp_err),   64'd0);
      check("rst_inst_resp_data",  64'(inst_resp_data),  64'd0);
      check("rst_data_resp_rdata", data_resp_rdata,      64'd0);
      rst = 1'b0;

      // Preload words 0 and 2 through the data port.
      data_req(1'b1, BASE,          64'hAAAA_BBBB_1111_2222, '1, 64'd0, 1'b0, 1);
      data_req(1'b1, BASE + 64'h10, 64'h0123_4567_89AB_CDEF, '1, 64'd0, 1'b0, 1);
      wait_idle();

      // Fetch both halves of word 0.
      inst_req(BASE,          32'h1111_2222, 1'b0);
      inst_req(BASE + 64'h4,  32'hAAAA_BBBB, 1'b0);

      // Masked store to the upper half of word 2, then read it back.
      data_req(1'b1, BASE + 64'h10, 64'hDEAD_BEEF_0000_0000,
               64'hFFFF_FFFF_0000_0000, 64'd0, 1'b0, 1);
      data_req(1'b0, BASE + 64'h10, '0, '0, 64'hDEAD_BEEF_89AB_CDEF, 1'b0, 1);
      wait_idle();

      // Out-of-range accesses: below the window and exactly at its end.
      data_req(1'b0, 64'h7FFF_FFF8, '0, '0, 64'd0, 1'b1, 1);
      data_req(1'b1, BASE + MEMB, 64'h5555_5555_5555_5555, '1, 64'd0, 1'b1, 1);
      inst_req(64'h7FFF_FFFC, 32'd0, 1'b1);
      // The rejected store aliases word 0 in the store; it must be intact.
      data_req(1'b0, BASE, '0, '0, 64'hAAAA_BBBB_1111_2222, 1'b0, 1);
      wait_idle();

      // Fetch and store to word 2 on the same edge: fetch sees the old value.
      fork
         inst_req(BASE + 64'h10, 32'h89AB_CDEF, 1'b0);
         data_req(1'b1, BASE + 64'h10, 64'h0000_0000_1234_5678,
                  64'h0000_0000_FFFF_FFFF, 64'd0, 1'b0, 1);
      join
      data_req(1'b0, BASE + 64'h10, '0, '0, 64'hDEAD_BEEF_1234_5678, 1'b0, 1);
      inst_req(BASE + 64'h14, 32'hDEAD_BEEF, 1'b0);
      wait_idle();

      // Backpressure: hold the data response for 5 cycles.
      @(posedge clk); #1;
      data_resp_ready = 1'b0;
      data_req(1'b0, BASE, '0, '0, 64'hAAAA_BBBB_1111_2222, 1'b0, 1);
      n = 0;
      while (!data_resp_valid && n < 20) begin
         @(negedge clk);
         n++;
      end
      check("bp_resp_seen", 64'(data_resp_valid), 64'd1);
      repeat (5) begin
         @(negedge clk);
         check("bp_resp_valid", 64'(data_resp_valid), 64'd1);
         check("bp_rdata",      data_resp_rdata,      64'hAAAA_BBBB_1111_2222);
         check("bp_req_ready",  64'(data_req_ready),  64'd0);
      end
      @(posedge clk); #1;
      data_resp_ready = 1'b1;
      @(negedge clk);
      check("bp_handshake_req_ready", 64'(data_req_ready), 64'd0);
      @(negedge clk);
      check("bp_release_req_ready",  64'(data_req_ready),  64'd1);
      check("bp_release_resp_valid", 64'(data_resp_valid), 64'd0);
      wait_idle();

      // Reset mid-WAIT: the store's response is dropped, the store itself kept.
      data_req(1'b1, BASE + 64'h18, 64'h0F0F_0F0F_F0F0_F0F0, '1, 64'd0, 1'b0, 0);
      rst = 1'b1;
      #1;
      check("rstwait_resp_valid", 64'(data_resp_valid), 64'd0);
      check("rstwait_req_ready",  64'(data_req_ready),  64'd1);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (6) @(negedge clk);
      data_req(1'b0, BASE + 64'h18, '0, '0, 64'h0F0F_0F0F_F0F0_F0F0, 1'b0, 1);
      wait_idle();

      check("end_inst_q_empty", 64'(inst_q.size()), 64'd0);
      check("end_data_q_empty", 64'(data_q.size()), 64'd0);

      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule
